// File: rtl/dram_mmio.sv
// Data-side memory for the core DRAM port: on-chip data RAM plus an MMIO register window.
// Latency: reads are combinational (0 cycles); writes are visible in the cycle after the edge.
// Backpressure: none toward the core; the console TX FIFO drops pushes when full and flags overflow.
//
// Ports: clk/rst (sync, active-high); dram_addr/dram_wr_data/dram_wr_en/dram_rd_en/dram_mask in,
//        dram_rd_data out; led[15:0], irq_timer; tx_valid/tx_data out with tx_ready in.
module dram_mmio #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MASK_WIDTH = 4,
    parameter int RAM_WORDS  = 4096,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] dram_addr,
    input  logic [DATA_WIDTH-1:0] dram_wr_data,
    input  logic                  dram_wr_en,
    input  logic                  dram_rd_en,
    input  logic [MASK_WIDTH-1:0] dram_mask,
    output logic [DATA_WIDTH-1:0] dram_rd_data,
    output logic [15:0]           led,
    output logic                  irq_timer,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready
);
    localparam int RAM_AW  = $clog2(RAM_WORDS);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = FIFO_AW + 1;

    // Register select is the word offset dram_addr[7:2]
    localparam logic [5:0] REG_LED    = 6'h00;
    localparam logic [5:0] REG_CYC_LO = 6'h01;
    localparam logic [5:0] REG_CYC_HI = 6'h02;
    localparam logic [5:0] REG_CMP    = 6'h03;
    localparam logic [5:0] REG_STAT   = 6'h04;
    localparam logic [5:0] REG_TX     = 6'h05;

    logic [DATA_WIDTH-1:0] ram [RAM_WORDS];
    logic [7:0]            fifo_mem [FIFO_DEPTH];

    logic [15:0]        led_q, led_d;
    logic [63:0]        cycle_q, cycle_d;
    logic [31:0]        snap_q, snap_d;
    logic [31:0]        cmp_q, cmp_d;
    logic               match_q, match_d;
    logic               ovf_q, ovf_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               is_mmio;
    logic [5:0]         reg_sel;
    logic [RAM_AW-1:0]  ram_idx;
    logic               ram_wr, reg_wr, reg_rd;
    logic               fifo_full, push_req, push_ok, pop;
    logic [31:0]        mmio_rd;
    logic               unused_addr;

    assign is_mmio   = dram_addr[ADDR_WIDTH-1];
    assign reg_sel   = dram_addr[7:2];
    assign ram_idx   = dram_addr[2 +: RAM_AW];
    assign ram_wr    = dram_wr_en && !is_mmio && !rst;
    assign reg_wr    = dram_wr_en && is_mmio;
    assign reg_rd    = dram_rd_en && is_mmio;

    // Byte offset bits and RAM alias bits play no part in decode
    assign unused_addr = ^{dram_addr[1:0], dram_addr[ADDR_WIDTH-2:RAM_AW+2]};

    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign tx_valid  = (count_q != '0);
    assign tx_data   = tx_valid ? fifo_mem[rd_ptr_q] : 8'h00;
    assign pop       = tx_valid && tx_ready;
    assign push_req  = reg_wr && (reg_sel == REG_TX) && dram_mask[0];
    // A pop in the same cycle frees the slot a full FIFO needs
    assign push_ok   = push_req && (!fifo_full || pop);

    assign led       = led_q;
    assign irq_timer = match_q;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        led_d    = led_q;
        cycle_d  = cycle_q + 64'd1;
        snap_d   = snap_q;
        cmp_d    = cmp_q;
        match_d  = match_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Reading the low half freezes the high half so a LO/HI pair is coherent
        if (reg_rd && (reg_sel == REG_CYC_LO)) snap_d = cycle_q[63:32];

        if (reg_wr) begin
            case (reg_sel)
                REG_LED: begin
                    if (dram_mask[0]) led_d[7:0]  = dram_wr_data[7:0];
                    if (dram_mask[1]) led_d[15:8] = dram_wr_data[15:8];
                end
                REG_CMP:  cmp_d = lane_merge(cmp_q, dram_wr_data[31:0], dram_mask);
                REG_STAT: begin
                    if (dram_mask[0] && dram_wr_data[0]) match_d = 1'b0;
                    if (dram_mask[1] && dram_wr_data[8]) ovf_d   = 1'b0;
                end
                default: ;
            endcase
        end

        // Sets come after clears so a same-cycle event is never lost
        if (cycle_q[31:0] == cmp_q) match_d = 1'b1;
        if (push_req && !push_ok)   ovf_d   = 1'b1;

        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        mmio_rd = '0;
        case (reg_sel)
            REG_LED:    mmio_rd = {16'h0000, led_q};
            REG_CYC_LO: mmio_rd = cycle_q[31:0];
            REG_CYC_HI: mmio_rd = snap_q;
            REG_CMP:    mmio_rd = cmp_q;
            REG_STAT:   mmio_rd = {23'h0, ovf_q, 7'h0, match_q};
            REG_TX:     mmio_rd[CNT_W:0] = {count_q, fifo_full};
            default: ;
        endcase
        dram_rd_data = '0;
        if (dram_rd_en && !rst) dram_rd_data = is_mmio ? DATA_WIDTH'(mmio_rd) : ram[ram_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q    <= '0;
            cycle_q  <= '0;
            snap_q   <= '0;
            cmp_q    <= '1;
            match_q  <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            led_q    <= led_d;
            cycle_q  <= cycle_d;
            snap_q   <= snap_d;
            cmp_q    <= cmp_d;
            match_q  <= match_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage arrays are not reset; only the pointers/count define validity
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < MASK_WIDTH; i++) begin
                if (dram_mask[i]) ram[ram_idx][8*i +: 8] <= dram_wr_data[8*i +: 8];
            end
        end
        if (push_ok && !rst) fifo_mem[wr_ptr_q] <= dram_wr_data[7:0];
    end
endmodule
